lp805x_sfifo: RTL and testbench

LP805X_SFIFO -- requirements
Module: lp805x_sfifo

---
 rtl/lp805x_sfifo_pkg.sv | 30 +++
 rtl/lp805x_fifo_defs.vh | 22 ++
 rtl/lp805x_sfifo_mem.sv | 30 +++
 rtl/lp805x_sfifo.sv | 126 ++++++++++++
 tb/tb_lp805x_sfifo.sv | 171 +++++++++++++++++
 5 files changed

// File: rtl/lp805x_sfifo_pkg.sv
// lp805x_sfifo_pkg: shared types and defaults for the synchronous FIFO.
`include "lp805x_fifo_defs.vh"

package lp805x_sfifo_pkg;

  // Default geometry, taken from the shared include.
  localparam int DEF_DATA_WIDTH = `LP805X_FIFO_DATA_WIDTH;
  localparam int DEF_ADDR_WIDTH = `LP805X_FIFO_ADDR_WIDTH;

  // What the FIFO does to its occupancy in one cycle.
  typedef enum logic [1:0] {
    OP_IDLE = 2'b00,
    OP_PUSH = 2'b01,
    OP_POP  = 2'b10,
    OP_BOTH = 2'b11
  } fifo_op_e;

  // Combine the accepted write/read strobes into a single operation code.
  function automatic fifo_op_e decode_op(input logic wr_acc, input logic rd_acc);
    fifo_op_e op;
    case ({rd_acc, wr_acc})
      2'b01:   op = OP_PUSH;
      2'b10:   op = OP_POP;
      2'b11:   op = OP_BOTH;
      default: op = OP_IDLE;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/lp805x_fifo_defs.vh
// Shared constants for the lp805x FIFO family.
// Holds the default word width and depth, and the guard for the
// LP805X_SFIFO_FWFT_EN build macro (first-word-fall-through read port).
`ifndef LP805X_FIFO_DEFS_VH
`define LP805X_FIFO_DEFS_VH

// Default stored word width in bits.
`define LP805X_FIFO_DATA_WIDTH 40

// Default log2 of FIFO depth.
`define LP805X_FIFO_ADDR_WIDTH 2

// Read-port mode selected by LP805X_SFIFO_FWFT_EN:
//   1 = data_out shows the head word combinationally whenever rrdy is high
//   0 = data_out is a register loaded on each accepted read
`ifdef LP805X_SFIFO_FWFT_EN
  `define LP805X_SFIFO_FWFT_MODE 1
`else
  `define LP805X_SFIFO_FWFT_MODE 0
`endif

`endif

// File: rtl/lp805x_sfifo_mem.sv
// lp805x_sfifo_mem: FIFO storage array, one synchronous write port and
// one asynchronous read port.
module lp805x_sfifo_mem #(
  parameter int DATA_WIDTH = 40,
  parameter int ADDR_WIDTH = 2
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Write the addressed word on an accepted push.
  // NOTE: the array has no reset; contents are only ever read after being
  // written, and a reset would prevent mapping onto RAM/LUT-RAM primitives.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/lp805x_sfifo.sv
// lp805x_sfifo: single-clock FIFO with occupancy count, almost-full /
// almost-empty flags and a sticky overflow/underflow error flag.
// Build macro LP805X_SFIFO_FWFT_EN selects a first-word-fall-through read
// port; by default data_out is registered with one cycle of read latency.
`include "lp805x_fifo_defs.vh"

module lp805x_sfifo
  import lp805x_sfifo_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int AFULL_LVL  = (1 << ADDR_WIDTH) - 1,
  parameter int AEMPTY_LVL = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  wput,
  output logic                  wrdy,
  output logic [DATA_WIDTH-1:0] data_out,
  input  logic                  rget,
  output logic                  rrdy,
  input  logic                  flush,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  afull,
  output logic                  aempty,
  output logic                  err
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  typedef logic [ADDR_WIDTH-1:0] ptr_t;
  typedef logic [ADDR_WIDTH:0]   cnt_t;

  localparam cnt_t FULL_CNT = cnt_t'(DEPTH);

  ptr_t                  wptr;
  ptr_t                  rptr;
  cnt_t                  count_q;
  logic                  err_q;
  logic [DATA_WIDTH-1:0] rd_data;

  logic                  wr_acc;
  logic                  rd_acc;
  logic                  reject;
  fifo_op_e              op;

  // Ready flags depend only on registered occupancy, never on requests.
  assign wrdy = (count_q != FULL_CNT);
  assign rrdy = (count_q != '0);

  // A flush swallows both requests, so nothing is accepted or rejected then.
  assign wr_acc = wput & wrdy & ~flush;
  assign rd_acc = rget & rrdy & ~flush;
  assign reject = ~flush & ((wput & ~wrdy) | (rget & ~rrdy));
  assign op     = decode_op(wr_acc, rd_acc);

  // Pointers, occupancy and sticky error; flush has priority over traffic.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr    <= '0;
      rptr    <= '0;
      count_q <= '0;
      err_q   <= 1'b0;
    end else if (flush) begin
      wptr    <= '0;
      rptr    <= '0;
      count_q <= '0;
      err_q   <= 1'b0;
    end else begin
      if (wr_acc) begin
        wptr <= wptr + ptr_t'(1);
      end
      if (rd_acc) begin
        rptr <= rptr + ptr_t'(1);
      end
      case (op)
        OP_PUSH: count_q <= count_q + cnt_t'(1);
        OP_POP:  count_q <= count_q - cnt_t'(1);
        default: count_q <= count_q;
      endcase
      if (reject) begin
        err_q <= 1'b1;
      end
    end
  end

  lp805x_sfifo_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_mem (
    .clk   (clk),
    .we    (wr_acc),
    .waddr (wptr),
    .wdata (data_in),
    .raddr (rptr),
    .rdata (rd_data)
  );

`ifdef LP805X_SFIFO_FWFT_EN
  // Head word is visible as soon as it is stored; a read just moves rptr on.
  assign data_out = rd_data;
`else
  logic [DATA_WIDTH-1:0] data_out_q;

  // Capture the head word on the edge that accepts a read; hold otherwise,
  // including across flush.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_out_q <= '0;
    end else if (rd_acc) begin
      data_out_q <= rd_data;
    end
  end

  assign data_out = data_out_q;
`endif

  assign count  = count_q;
  assign err    = err_q;
  assign afull  = (int'(count_q) >= AFULL_LVL);
  assign aempty = (int'(count_q) <= AEMPTY_LVL);

endmodule

// File: tb/tb_lp805x_sfifo.sv
// tb_lp805x_sfifo: scoreboard bench for lp805x_sfifo (8-bit words, depth 4,
// afull at 3, aempty at 1). Works for both read-port builds.
`timescale 1ns/1ps

module tb_lp805x_sfifo;

  localparam int DW    = 8;
  localparam int AW    = 2;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [DW-1:0] data_in = '0;
  logic          wput = 1'b0;
  logic          rget = 1'b0;
  logic          flush = 1'b0;
  logic          wrdy;
  logic          rrdy;
  logic [DW-1:0] data_out;
  logic [AW:0]   count;
  logic          afull;
  logic          aempty;
  logic          err;

  lp805x_sfifo #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW),
    .AFULL_LVL  (3),
    .AEMPTY_LVL (1)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .data_in  (data_in),
    .wput     (wput),
    .wrdy     (wrdy),
    .data_out (data_out),
    .rget     (rget),
    .rrdy     (rrdy),
    .flush    (flush),
    .count    (count),
    .afull    (afull),
    .aempty   (aempty),
    .err      (err)
  );

  always #5 clk = ~clk;

  int            n_checks = 0;
  int            n_pass   = 0;
  logic [DW-1:0] sb [$];
  int            m_count  = 0;
  logic          m_err    = 1'b0;
  logic [DW-1:0] exp_dout = '0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Compare every status output against the model.
  task automatic check_state(input string tag);
    check({tag, "_count"},  64'(count),  64'(m_count));
    check({tag, "_wrdy"},   64'(wrdy),   64'(m_count != DEPTH));
    check({tag, "_rrdy"},   64'(rrdy),   64'(m_count != 0));
    check({tag, "_afull"},  64'(afull),  64'(m_count >= 3));
    check({tag, "_aempty"}, 64'(aempty), 64'(m_count <= 1));
    check({tag, "_err"},    64'(err),    64'(m_err));
`ifdef LP805X_SFIFO_FWFT_EN
    if (m_count != 0) check({tag, "_head"}, 64'(data_out), 64'(sb[0]));
`else
    check({tag, "_dout"}, 64'(data_out), 64'(exp_dout));
`endif
  endtask

  // One clock of stimulus; the model predicts acceptance before the edge.
  task automatic do_op(input string tag, input logic w, input logic [DW-1:0] d,
                       input logic r, input logic f);
    logic aw;
    logic ar;
    wput = w; data_in = d; rget = r; flush = f;
    #1;
    aw = w && (m_count != DEPTH) && !f;
    ar = r && (m_count != 0) && !f;
`ifdef LP805X_SFIFO_FWFT_EN
    if (ar) check({tag, "_fwft_rd"}, 64'(data_out), 64'(sb[0]));
`endif
    @(posedge clk);
    #1;
    if (f) begin
      sb.delete();
      m_err = 1'b0;
    end else begin
      if ((w && !aw) || (r && !ar)) m_err = 1'b1;
      if (ar) begin
        exp_dout = sb.pop_front();
`ifndef LP805X_SFIFO_FWFT_EN
        check({tag, "_rd"}, 64'(data_out), 64'(exp_dout));
`endif
      end
      if (aw) sb.push_back(d);
    end
    m_count = sb.size();
    wput = 1'b0; rget = 1'b0; flush = 1'b0;
    check_state(tag);
  endtask

  initial begin
    logic [DW-1:0] seq [4];
    seq[0] = 8'h11; seq[1] = 8'h22; seq[2] = 8'h33; seq[3] = 8'h44;

    // Reset
    #12 rst_n = 1'b1;
    @(negedge clk);
    check_state("reset");

    // Fill to full, then drain in order
    for (int i = 0; i < 4; i++) do_op("fill", 1'b1, seq[i], 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) do_op("drain", 1'b0, 8'h00, 1'b1, 1'b0);

    // Full: simultaneous put/get -> read wins, write rejected, err set
    for (int i = 0; i < 4; i++) do_op("fill2", 1'b1, 8'hA1 + 8'(i), 1'b0, 1'b0);
    do_op("full_both", 1'b1, 8'h55, 1'b1, 1'b0);
    do_op("flush1", 1'b0, 8'h00, 1'b0, 1'b1);

    // Steady streaming at count 2 across two pointer wraps
    do_op("pre", 1'b1, 8'hE1, 1'b0, 1'b0);
    do_op("pre", 1'b1, 8'hE2, 1'b0, 1'b0);
    for (int i = 1; i <= 10; i++) do_op("stream", 1'b1, 8'(i), 1'b1, 1'b0);
    do_op("post", 1'b0, 8'h00, 1'b1, 1'b0);
    do_op("post", 1'b0, 8'h00, 1'b1, 1'b0);

    // Underflow, then flush beats a concurrent write
    do_op("underflow", 1'b0, 8'h00, 1'b1, 1'b0);
    do_op("flush_wr", 1'b1, 8'h77, 1'b0, 1'b1);

    // Empty: simultaneous put/get -> write wins, read rejected
    do_op("empty_both", 1'b1, 8'h3C, 1'b1, 1'b0);
    do_op("flush2", 1'b0, 8'h00, 1'b0, 1'b1);

    // Asynchronous reset between edges with data loaded
    for (int i = 0; i < 3; i++) do_op("load3", 1'b1, 8'hC0 + 8'(i), 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    sb.delete(); m_count = 0; m_err = 1'b0; exp_dout = '0;
    check_state("async_rst");
    @(negedge clk);
    rst_n = 1'b1;
    do_op("post_rst", 1'b1, 8'h5A, 1'b0, 1'b0);
    do_op("post_rst", 1'b0, 8'h00, 1'b1, 1'b0);

`ifdef LP805X_SFIFO_FWFT_EN
    // Single word falls through without a read request
    do_op("fwft_wr", 1'b1, 8'hA5, 1'b0, 1'b0);
    check("fwft_vis_rrdy", 64'(rrdy), 64'(1));
    check("fwft_vis_data", 64'(data_out), 64'hA5);
    do_op("fwft_pop", 1'b0, 8'h00, 1'b1, 1'b0);
`endif

    // Random traffic with occasional flush
    for (int i = 0; i < 300; i++) begin
      do_op("rand", 1'($urandom_range(0, 1)), 8'($urandom),
            1'($urandom_range(0, 1)), ($urandom_range(0, 31) == 0));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
